// File: rtl/simplez_sequencer_if.sv
// Control-unit bundle between the Simplez sequencer and its datapath:
// instruction/flag inputs towards the sequencer, microorders, status back out.
interface simplez_sequencer_if;
    logic [2:0]  opcode;
    logic        z;
    logic        start;
    logic        lec, esc;
    logic        eri, sri, era, incp, ccp, scp, eac, sac;
    logic        sum, clr, dec;
    logic        stop;
    logic [2:0]  state;
    logic [15:0] icount;

    // Sequencer side: consumes opcode/flags, drives microorders and status.
    modport master (
        input  opcode, z, start,
        output lec, esc, eri, sri, era, incp, ccp, scp, eac, sac,
               sum, clr, dec, stop, state, icount
    );

    // Datapath side: supplies opcode/flags, obeys microorders.
    modport slave (
        output opcode, z, start,
        input  lec, esc, eri, sri, era, incp, ccp, scp, eac, sac,
               sum, clr, dec, stop, state, icount
    );
endinterface

// File: rtl/simplez_sequencer.sv
// Simplez control unit: fetch/execute sequencer with a configurable number of
// memory wait cycles, a halt state with level resume, and an instruction counter.
// State and counters advance on the falling clock edge.
module simplez_sequencer #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                clk,
    input  logic                rst,
    simplez_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_I0   = 3'd0,
        S_I1   = 3'd1,
        S_O0   = 3'd2,
        S_O1   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    typedef struct packed {
        logic lec, esc, eri, sri, era, incp, ccp, scp, eac, sac, sum, clr, dec, stop;
    } ctl_t;

    localparam logic [2:0] OP_ST  = 3'd0, OP_LD  = 3'd1, OP_ADD = 3'd2, OP_BR  = 3'd3,
                           OP_BZ  = 3'd4, OP_CLR = 3'd5, OP_DEC = 3'd6, OP_HLT = 3'd7;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t      st, st_nxt;
    logic [3:0]  wcnt, wcnt_nxt;
    logic [15:0] icnt;
    logic        icnt_inc;
    ctl_t        c;

    logic last, mem_op;
    assign last   = (wcnt == WAIT_LAST);
    assign mem_op = (bus.opcode == OP_ST) || (bus.opcode == OP_LD) || (bus.opcode == OP_ADD);

    // State, wait counter and instruction counter; reset aborts any access.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            st   <= S_I0;
            wcnt <= '0;
            icnt <= '0;
        end else begin
            st   <= st_nxt;
            wcnt <= wcnt_nxt;
            if (icnt_inc) icnt <= icnt + 16'd1;
        end
    end

    // Next state and microorders from state, wait count, opcode and z.
    always_comb begin
        c        = '0;
        st_nxt   = st;
        wcnt_nxt = '0;   // any state change clears the wait counter
        icnt_inc = 1'b0;
        case (st)
            S_I0: begin
                c.lec = 1'b1;
                if (last) begin
                    c.eri  = 1'b1;
                    c.incp = 1'b1;
                    st_nxt = S_I1;
                end else begin
                    wcnt_nxt = wcnt + 4'd1;
                end
            end
            S_I1: begin
                if (bus.opcode != OP_HLT && !mem_op) icnt_inc = 1'b1;
                case (bus.opcode)
                    OP_ST, OP_LD, OP_ADD: begin
                        c.sri = 1'b1; c.era = 1'b1;
                        st_nxt = S_O0;
                    end
                    OP_BR: begin
                        c.sri = 1'b1; c.era = 1'b1; c.ccp = 1'b1;
                        st_nxt = S_I0;
                    end
                    OP_BZ: begin
                        c.era = 1'b1;
                        if (bus.z) begin
                            c.sri = 1'b1; c.ccp = 1'b1;
                        end else begin
                            c.scp = 1'b1;
                        end
                        st_nxt = S_I0;
                    end
                    OP_CLR: begin
                        c.eac = 1'b1; c.clr = 1'b1; c.scp = 1'b1; c.era = 1'b1;
                        st_nxt = S_I0;
                    end
                    OP_DEC: begin
                        c.eac = 1'b1; c.dec = 1'b1; c.scp = 1'b1; c.era = 1'b1;
                        st_nxt = S_I0;
                    end
                    default: begin
                        icnt_inc = 1'b1;   // HALT counts as a completed instruction
                        st_nxt   = S_HALT;
                    end
                endcase
            end
            S_O0: begin
                // Write keeps the accumulator on the bus for the whole access.
                case (bus.opcode)
                    OP_ST:  begin c.esc = 1'b1; c.sac = 1'b1; end
                    OP_LD:  begin c.lec = 1'b1; c.eac = last; end
                    OP_ADD: begin c.lec = 1'b1; c.eac = last; c.sum = last; end
                    default: ;
                endcase
                if (mem_op && !last) wcnt_nxt = wcnt + 4'd1;
                else                 st_nxt   = S_O1;
            end
            S_O1: begin
                c.scp = 1'b1; c.era = 1'b1;
                icnt_inc = 1'b1;
                st_nxt   = S_I0;
            end
            S_HALT: begin
                c.stop = 1'b1;
                if (bus.start) begin
                    c.scp = 1'b1; c.era = 1'b1;
                    st_nxt = S_I0;
                end
            end
            default: st_nxt = S_I0;
        endcase
        // Hold every control line low while reset is asserted.
        if (rst) c = '0;
    end

    assign bus.lec    = c.lec;
    assign bus.esc    = c.esc;
    assign bus.eri    = c.eri;
    assign bus.sri    = c.sri;
    assign bus.era    = c.era;
    assign bus.incp   = c.incp;
    assign bus.ccp    = c.ccp;
    assign bus.scp    = c.scp;
    assign bus.eac    = c.eac;
    assign bus.sac    = c.sac;
    assign bus.sum    = c.sum;
    assign bus.clr    = c.clr;
    assign bus.dec    = c.dec;
    assign bus.stop   = c.stop;
    assign bus.state  = st;
    assign bus.icount = icnt;
endmodule
